// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_run_ctrl
// Purpose  : Run control for the riscv core. Generates the core's active-low
//            reset (held for ResetCycles after reset or RESET_CORE) and its
//            clock enable, and handles RUN/HALT/STEP/RESET_CORE commands,
//            PC breakpoints, a retired-instruction timeout, and saturating
//            cycle/retired counters.
// Ports    : clk_i, rst_i (async, active-low)
//            cmd_valid_i/cmd_i/cmd_ready_o   command handshake
//            bp_we_i/bp_idx_i/bp_addr_i/bp_en_i  breakpoint slot write
//            pc_i                              core PC
//            core_rst_o, core_en_o             core reset / clock enable
//            state_o, halted_o, halt_cause_o   status
//            cycle_cnt_o, retired_cnt_o        counters
// Revision : 1.0  initial release
// ============================================================================
module riscv_run_ctrl #(
    parameter int RegBits        = 32,
    parameter int NumBreakpoints = 2,
    parameter int ResetCycles    = 4,
    parameter int CounterBits    = 32,
    parameter int MaxCycles      = 0,
    parameter int AutoRun        = 1,
    localparam int IdxBits       = (NumBreakpoints > 1) ? $clog2(NumBreakpoints) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    input  logic [1:0]             cmd_i,
    output logic                   cmd_ready_o,
    input  logic                   bp_we_i,
    input  logic [IdxBits-1:0]     bp_idx_i,
    input  logic [RegBits-1:0]     bp_addr_i,
    input  logic                   bp_en_i,
    input  logic [RegBits-1:0]     pc_i,
    output logic                   core_rst_o,
    output logic                   core_en_o,
    output logic [1:0]             state_o,
    output logic                   halted_o,
    output logic [1:0]             halt_cause_o,
    output logic [CounterBits-1:0] cycle_cnt_o,
    output logic [CounterBits-1:0] retired_cnt_o
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'b00,
        ST_HALTED   = 2'b01,
        ST_RUNNING  = 2'b10,
        ST_STEPPING = 2'b11
    } state_e;

    localparam logic [1:0] CMD_RUN       = 2'd0;
    localparam logic [1:0] CMD_HALT      = 2'd1;
    localparam logic [1:0] CMD_STEP      = 2'd2;
    localparam logic [1:0] CMD_RESETCORE = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_CMD  = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_TO   = 2'b11;

    localparam int                     HoldBits = $clog2(ResetCycles + 1);
    localparam logic [HoldBits-1:0]    HoldInit = HoldBits'(ResetCycles);
    localparam logic [HoldBits-1:0]    HoldLast = HoldBits'(1);
    localparam logic [CounterBits-1:0] CntMax   = '1;
    localparam logic [CounterBits-1:0] CntOne   = CounterBits'(1);
    localparam logic [CounterBits-1:0] MaxCnt   = CounterBits'(MaxCycles);

    state_e                   state_q, state_d;
    logic [HoldBits-1:0]      hold_q, hold_d;
    logic                     skip_q, skip_d;
    logic                     core_rst_q, core_rst_d;
    logic [1:0]               cause_q, cause_d;
    logic [CounterBits-1:0]   cycle_q, cycle_d;
    logic [CounterBits-1:0]   retired_q, retired_d;
    logic [RegBits-1:0]       bp_addr_q [NumBreakpoints];
    logic [RegBits-1:0]       bp_addr_d [NumBreakpoints];
    logic [NumBreakpoints-1:0] bp_en_q, bp_en_d;

    logic bp_hit;
    logic timeout;
    logic cmd_acc;
    logic enter_reset;

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NumBreakpoints; i++) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc_i)) begin
                bp_hit = 1'b1;
            end
        end
    end

    assign timeout     = (MaxCycles != 0) && (retired_q >= MaxCnt);
    assign cmd_ready_o = (state_q == ST_HALTED) || (state_q == ST_RUNNING);
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;

    // skip lets a RUN issued while parked on a breakpoint PC execute it once.
    assign core_en_o = (state_q == ST_STEPPING) ||
                       ((state_q == ST_RUNNING) && !(bp_hit && !skip_q) && !timeout);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        skip_d      = skip_q;
        core_rst_d  = core_rst_q;
        cause_d     = cause_q;
        enter_reset = 1'b0;
        cycle_d     = (core_rst_q && (cycle_q != CntMax)) ? cycle_q + CntOne : cycle_q;
        retired_d   = (core_en_o && (retired_q != CntMax)) ? retired_q + CntOne : retired_q;

        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;
        if (bp_we_i) begin
            for (int i = 0; i < NumBreakpoints; i++) begin
                if (bp_idx_i == IdxBits'(i)) begin
                    bp_addr_d[i] = bp_addr_i;
                    bp_en_d[i]   = bp_en_i;
                end
            end
        end

        case (state_q)
            ST_RESET: begin
                if (hold_q <= HoldLast) begin
                    core_rst_d = 1'b1;
                    skip_d     = 1'b0;
                    cause_d    = CAUSE_NONE;
                    state_d    = (AutoRun != 0) ? ST_RUNNING : ST_HALTED;
                end else begin
                    hold_d = hold_q - HoldLast;
                end
            end
            ST_HALTED: begin
                if (cmd_acc) begin
                    case (cmd_i)
                        CMD_RUN: begin
                            state_d = ST_RUNNING;
                            skip_d  = 1'b1;
                            cause_d = CAUSE_NONE;
                        end
                        CMD_STEP: begin
                            state_d = ST_STEPPING;
                            cause_d = CAUSE_NONE;
                        end
                        CMD_RESETCORE: enter_reset = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUNNING: begin
                skip_d = 1'b0;
                // Priority: RESET_CORE > breakpoint > timeout > HALT.
                if (cmd_acc && (cmd_i == CMD_RESETCORE)) begin
                    enter_reset = 1'b1;
                end else if (bp_hit && !skip_q) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (timeout) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_TO;
                end else if (cmd_acc && (cmd_i == CMD_HALT)) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_CMD;
                end
            end
            ST_STEPPING: begin
                state_d = ST_HALTED;
                cause_d = CAUSE_CMD;
            end
            default: state_d = ST_RESET;
        endcase

        if (enter_reset) begin
            state_d    = ST_RESET;
            hold_d     = HoldInit;
            core_rst_d = 1'b0;
            skip_d     = 1'b0;
            cause_d    = CAUSE_NONE;
            cycle_d    = '0;
            retired_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RESET;
            hold_q     <= HoldInit;
            skip_q     <= 1'b0;
            core_rst_q <= 1'b0;
            cause_q    <= CAUSE_NONE;
            cycle_q    <= '0;
            retired_q  <= '0;
            bp_en_q    <= '0;
            for (int i = 0; i < NumBreakpoints; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            skip_q     <= skip_d;
            core_rst_q <= core_rst_d;
            cause_q    <= cause_d;
            cycle_q    <= cycle_d;
            retired_q  <= retired_d;
            bp_en_q    <= bp_en_d;
            bp_addr_q  <= bp_addr_d;
        end
    end

    assign core_rst_o    = core_rst_q;
    assign state_o       = state_q;
    assign halted_o      = (state_q == ST_HALTED);
    assign halt_cause_o  = cause_q;
    assign cycle_cnt_o   = cycle_q;
    assign retired_cnt_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_run_ctrl
// Purpose  : Directed self-checking bench for riscv_run_ctrl. Instance dut uses
//            default parameters (breakpoints, stepping, HALT, resets); instance
//            dut_t uses MaxCycles=8, CounterBits=4 (timeout, saturation).
//            A tiny core model advances pc by 4 on every enabled cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut signals
    logic        rst_n, cmd_valid, bp_we, bp_en;
    logic [1:0]  cmd;
    logic        bp_idx;
    logic [31:0] bp_addr, pc;
    logic        cmd_ready, core_rst, core_en, halted;
    logic [1:0]  state, cause;
    logic [31:0] cycle_cnt, retired_cnt;

    // dut_t signals
    logic        rst_t, cmd_valid_t;
    logic [1:0]  cmd_t;
    logic        cmd_ready_t, core_rst_t, core_en_t, halted_t;
    logic [1:0]  state_t, cause_t;
    logic [3:0]  cycle_t, retired_t;

    int n_cmp = 0;
    int n_err = 0;

    riscv_run_ctrl dut (
        .clk_i(clk), .rst_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .cmd_ready_o(cmd_ready), .bp_we_i(bp_we), .bp_idx_i(bp_idx),
        .bp_addr_i(bp_addr), .bp_en_i(bp_en), .pc_i(pc),
        .core_rst_o(core_rst), .core_en_o(core_en), .state_o(state),
        .halted_o(halted), .halt_cause_o(cause),
        .cycle_cnt_o(cycle_cnt), .retired_cnt_o(retired_cnt)
    );

    riscv_run_ctrl #(.MaxCycles(8), .CounterBits(4)) dut_t (
        .clk_i(clk), .rst_i(rst_t), .cmd_valid_i(cmd_valid_t), .cmd_i(cmd_t),
        .cmd_ready_o(cmd_ready_t), .bp_we_i(1'b0), .bp_idx_i(1'b0),
        .bp_addr_i(32'h0), .bp_en_i(1'b0), .pc_i(pc),
        .core_rst_o(core_rst_t), .core_en_o(core_en_t), .state_o(state_t),
        .halted_o(halted_t), .halt_cause_o(cause_t),
        .cycle_cnt_o(cycle_t), .retired_cnt_o(retired_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample enable at negedge, advance pc after the edge.
    task automatic cyc();
        logic en;
        @(negedge clk);
        en = core_en;
        @(posedge clk);
        #1;
        if (en) pc = pc + 32'd4;
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic send_t(input logic [1:0] c);
        cmd_valid_t = 1'b1;
        cmd_t = c;
        cyc();
        cmd_valid_t = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst_t = 1'b0;
        cmd_valid = 1'b0; cmd = 2'd0; cmd_valid_t = 1'b0; cmd_t = 2'd0;
        bp_we = 1'b0; bp_idx = 1'b0; bp_addr = 32'h0; bp_en = 1'b0; pc = 32'h0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd0);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);

        // Release reset and program slot 0 = 0x10 during the hold.
        @(posedge clk); #2;
        rst_n = 1'b1;
        bp_we = 1'b1; bp_idx = 1'b0; bp_addr = 32'h10; bp_en = 1'b1;
        cyc();
        bp_we = 1'b0;
        cycn(2);
        check("hold3_core_rst", 32'(core_rst), 32'd0);
        cyc();
        check("hold4_core_rst", 32'(core_rst), 32'd1);
        check("autorun_state", 32'(state), 32'd2);
        check("autorun_en", 32'(core_en), 32'd1);
        check("autorun_cycle", cycle_cnt, 32'd0);
        cyc();
        check("cycle_inc", cycle_cnt, 32'd1);

        // Run 0x4, 0x8, 0xC; stop on 0x10.
        cycn(3);
        check("bp_en_low", 32'(core_en), 32'd0);
        check("bp_ret4", retired_cnt, 32'd4);
        cyc();
        check("bp_state", 32'(state), 32'd1);
        check("bp_cause", 32'(cause), 32'd2);
        check("bp_cycle", cycle_cnt, 32'd5);

        // RUN resumes from the breakpoint PC.
        send(2'd0);
        check("skip_en", 32'(core_en), 32'd1);
        cyc();
        check("resume_ret", retired_cnt, 32'd5);
        check("resume_pc14_en", 32'(core_en), 32'd1);

        // Slot 1 = 0x20; HALT arrives in the same cycle as the hit.
        bp_we = 1'b1; bp_idx = 1'b1; bp_addr = 32'h20; bp_en = 1'b1;
        cyc();
        bp_we = 1'b0;
        cycn(2);
        check("bp2_en_low", 32'(core_en), 32'd0);
        send(2'd1);
        check("bp_vs_halt_cause", 32'(cause), 32'd2);
        check("bp_vs_halt_ret", retired_cnt, 32'd8);

        // Three single steps, the first one sitting on a breakpoint PC.
        for (int k = 0; k < 3; k++) begin
            send(2'd2);
            check("step_en", 32'(core_en), 32'd1);
            check("step_state", 32'(state), 32'd3);
            cyc();
            check("step_state_back", 32'(state), 32'd1);
            check("step_en_off", 32'(core_en), 32'd0);
            check("step_cause", 32'(cause), 32'd1);
            check("step_ret", retired_cnt, 32'(9 + k));
        end

        // RUN then a plain HALT command.
        send(2'd0);
        cyc();
        check("run_ret", retired_cnt, 32'd12);
        cmd_valid = 1'b1; cmd = 2'd1;
        check("ready_running", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        check("halt_en", 32'(core_en), 32'd0);
        check("halt_state", 32'(state), 32'd1);
        check("halt_cause", 32'(cause), 32'd1);
        check("halt_ret", retired_cnt, 32'd13);

        // RESET_CORE clears counters and repeats the hold.
        send(2'd3);
        check("rc_state", 32'(state), 32'd0);
        check("rc_cycle", cycle_cnt, 32'd0);
        check("rc_ret", retired_cnt, 32'd0);
        check("rc_core_rst", 32'(core_rst), 32'd0);
        check("rc_ready", 32'(cmd_ready), 32'd0);
        cycn(3);
        check("rc_hold3", 32'(core_rst), 32'd0);
        cyc();
        check("rc_hold4", 32'(core_rst), 32'd1);
        check("rc_state_run", 32'(state), 32'd2);

        // Asynchronous reset mid-run.
        cycn(2);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_core_rst", 32'(core_rst), 32'd0);
        check("arst_en", 32'(core_en), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd0);
        check("arst_cycle", cycle_cnt, 32'd0);
        check("arst_ret", retired_cnt, 32'd0);
        pc = 32'h8;
        @(posedge clk); #2;
        rst_n = 1'b1;
        cycn(4);
        check("arst_rerun", 32'(state), 32'd2);
        cycn(2);
        check("slots_cleared_en", 32'(core_en), 32'd1);
        cyc();
        check("slots_cleared_ret", retired_cnt, 32'd3);

        // Timeout / saturation instance.
        rst_n = 1'b0;
        rst_t = 1'b1;
        cycn(4);
        check("t_run", 32'(state_t), 32'd2);
        cycn(8);
        check("t_ret8", 32'(retired_t), 32'd8);
        check("t_en_low", 32'(core_en_t), 32'd0);
        cyc();
        check("t_state", 32'(state_t), 32'd1);
        check("t_cause", 32'(cause_t), 32'd3);
        send_t(2'd0);
        check("t_run_en", 32'(core_en_t), 32'd0);
        cyc();
        check("t_rehalt_state", 32'(state_t), 32'd1);
        check("t_rehalt_cause", 32'(cause_t), 32'd3);
        check("t_rehalt_ret", 32'(retired_t), 32'd8);
        check("t_cycle11", 32'(cycle_t), 32'd11);
        cycn(6);
        check("t_cycle_sat", 32'(cycle_t), 32'd15);
        send_t(2'd3);
        check("t_rc_state", 32'(state_t), 32'd0);
        check("t_rc_cycle", 32'(cycle_t), 32'd0);
        check("t_rc_ret", 32'(retired_t), 32'd0);
        cycn(3);
        check("t_rc_hold3", 32'(core_rst_t), 32'd0);
        cyc();
        check("t_rc_hold4", 32'(core_rst_t), 32'd1);
        check("t_rc_run", 32'(state_t), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Parametrised run-control block between the RISC-V environment and the `riscv` core. It generates the core's active-low reset and clock enable, with a programmable post-reset hold and optional auto-run. It provides RUN/HALT/STEP/RESET_CORE commands, NumBreakpoints PC breakpoints and a retired-instruction timeout. It also exposes cycle and retired-instruction counters for the bench and debug logic.

## Interface
- RegBits, 32, PC width compared against breakpoints
- NumBreakpoints, 2, breakpoint slots (1..16)
- ResetCycles, 4, cycles core_rst_o is held low after reset or RESET_CORE (>=1)
- CounterBits, 32, width of both counters
- MaxCycles, 0, retired-instruction limit; 0 disables timeout
- AutoRun, 1, 1: enter RUNNING after reset hold; 0: enter HALTED
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command strobe
- cmd_i  in  2  0 RUN, 1 HALT, 2 STEP, 3 RESET_CORE
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o at rising edge
- bp_we_i  in  1  breakpoint write
- bp_idx_i  in  $clog2(NumBreakpoints) (min 1)  slot index
- bp_addr_i  in  RegBits  breakpoint PC
- bp_en_i  in  1  slot enable
- pc_i  in  RegBits  core's current PC
- core_rst_o  out  1  active-low core reset
- core_en_o  out  1  core clock enable (combinational)
- state_o  out  2  00 RESET, 01 HALTED, 10 RUNNING, 11 STEPPING
- halted_o  out  1  state_o == HALTED
- halt_cause_o  out  2  00 none, 01 command, 10 breakpoint, 11 timeout
- cycle_cnt_o  out  CounterBits  cycles with core_rst_o high
- retired_cnt_o  out  CounterBits  cycles with core_en_o high

## Operation
- RESET: core_rst_o=0, hold counter loaded with ResetCycles, decremented each cycle; at 0 drive core_rst_o=1 and go to RUNNING (AutoRun=1) or HALTED (AutoRun=0, cause none).
- HALTED: RUN -> RUNNING with skip flag set; STEP -> STEPPING; HALT no-op; RESET_CORE -> RESET.
- RUNNING: HALT -> HALTED (cause command); RESET_CORE -> RESET; RUN/STEP ignored but accepted.
- STEPPING: exactly one cycle, core_en_o=1 regardless of breakpoints/timeout, then HALTED (cause command).
- bp_hit = any enabled slot with bp_addr == pc_i. timeout = MaxCycles!=0 && retired_cnt_o >= MaxCycles.
- core_en_o = STEPPING || (RUNNING && !(bp_hit && !skip) && !timeout). skip clears after first RUNNING cycle; it lets RUN resume from a breakpoint PC.
- RUNNING with bp_hit && !skip: core_en_o=0 same cycle, HALTED next edge, cause breakpoint. timeout likewise, cause timeout.
- Priority in one cycle: RESET_CORE > breakpoint > timeout > HALT command.
- RUN after timeout re-halts immediately (cause timeout); only RESET_CORE or rst_i clears counters.
- Breakpoint write takes effect from next cycle; concurrent command is processed normally.
- Counters saturate at all ones; cleared by rst_i and on entering RESET via RESET_CORE. Breakpoint slots are cleared only by rst_i.

## Timing
- rst_i low: immediately state_o=00, core_rst_o=0, core_en_o=0, cmd_ready_o=0, halted_o=0, halt_cause_o=00, both counters 0, all slot enables 0.
- cmd_ready_o = state is HALTED or RUNNING.
- rst_i deassertion: core_rst_o rises after exactly ResetCycles rising edges; the first RUNNING cycle follows the same edge.
- HALT accepted at edge N: core_en_o low from cycle N+1.
- STEP accepted at edge N: core_en_o high for exactly cycle N+1; HALTED from edge N+1.
- Reset mid-operation (rst_i or RESET_CORE): core_en_o drops within the same cycle (rst_i) or next cycle (RESET_CORE); a pending skip is discarded.

## Test plan
- rst_i low then high, ResetCycles=4, AutoRun=1 -> core_rst_o rises after 4th edge, state_o=10, core_en_o=1, cycle_cnt_o increments per cycle.
- Slot 0 = 0x0000_0010 enabled, running from 0x0 -> core_en_o low when pc_i=0x10, halt_cause_o=10, retired_cnt_o=4; RUN -> executes 0x10, continues to 0x14.
- In HALTED, three STEP commands -> retired_cnt_o +3, each a single core_en_o pulse, state returns to 01 each time.
- MaxCycles=8, no breakpoints -> halts after retired_cnt_o=8, cause 11; RUN -> stays halted, retired_cnt_o still 8; RESET_CORE -> counters 0, reset hold repeats.
- HALT during RUNNING same cycle as bp hit -> cause 10; rst_i pulsed low mid-RUNNING -> all outputs at reset values asynchronously, slot enables cleared.
- Counter saturation with CounterBits=4 -> cycle_cnt_o sticks at 0xF.
